vga_display_core: RTL and testbench

//  Parametrised VGA raster engine: counts pixel/line position and generates sync and

---
 rtl/vga_display_core_if.sv | 36 +++
 rtl/vga_display_core.sv | 154 +++++++++++++++
 tb/tb_vga_display_core.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_display_core_if.sv
// Bundle of renderer colour inputs and raster/VGA outputs for vga_display_core.
// The core drives through the master modport; a renderer or bench sits on slave.
interface vga_display_core_if #(
  parameter int CORDW   = 10,
  parameter int RW      = 3,
  parameter int GW      = 3,
  parameter int BW      = 2,
  parameter int FRAME_W = 8
);
  logic [RW-1:0]      pix_r_in;
  logic [GW-1:0]      pix_g_in;
  logic [BW-1:0]      pix_b_in;
  logic [CORDW-1:0]   sx;
  logic [CORDW-1:0]   sy;
  logic               de;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt;
  logic               vga_hsync;
  logic               vga_vsync;
  logic [RW-1:0]      vga_r;
  logic [GW-1:0]      vga_g;
  logic [BW-1:0]      vga_b;

  modport master (
    input  pix_r_in, pix_g_in, pix_b_in,
    output sx, sy, de, line_start, frame_start, frame_cnt,
    output vga_hsync, vga_vsync, vga_r, vga_g, vga_b
  );

  modport slave (
    output pix_r_in, pix_g_in, pix_b_in,
    input  sx, sy, de, line_start, frame_start, frame_cnt,
    input  vga_hsync, vga_vsync, vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/vga_display_core.sv
// VGA raster engine: pixel/line counters, sync and data-enable generation, and an
// alignment pipeline that delays syncs/de to match the renderer's colour latency.
// Colour and syncs leave through a final register; colour is zeroed outside the
// active area so whatever the renderer produces during blanking never reaches the pins.
module vga_display_core #(
  parameter int CORDW      = 10,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit H_POL      = 1'b0,
  parameter bit V_POL      = 1'b0,
  parameter int RW         = 3,
  parameter int GW         = 3,
  parameter int BW         = 2,
  parameter int RENDER_LAT = 0,
  parameter int FRAME_W    = 8
) (
  input logic                clk_pix,
  input logic                rst,
  vga_display_core_if.master vgaBus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CORDW-1:0] H_LAST   = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] V_LAST   = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] H_ACT    = CORDW'(H_ACTIVE);
  localparam logic [CORDW-1:0] V_ACT    = CORDW'(V_ACTIVE);
  localparam logic [CORDW-1:0] HS_START = CORDW'(H_ACTIVE + H_FP);
  localparam logic [CORDW-1:0] HS_END   = CORDW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CORDW-1:0] VS_START = CORDW'(V_ACTIVE + V_FP);
  localparam logic [CORDW-1:0] VS_END   = CORDW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CORDW-1:0]   sx_q, sx_d;
  logic [CORDW-1:0]   sy_q, sy_d;
  logic [FRAME_W-1:0] frameCnt_q, frameCnt_d;

  logic hsActive, vsActive;
  logic hsLevel, vsLevel, deRaw;
  logic hsDly, vsDly, deDly;

  logic          vgaHsync_q, vgaVsync_q;
  logic [RW-1:0] vgaR_q;
  logic [GW-1:0] vgaG_q;
  logic [BW-1:0] vgaB_q;

  // Next raster position: step along the line, wrap to the next line, wrap the frame.
  always_comb begin
    sx_d       = sx_q + CORDW'(1);
    sy_d       = sy_q;
    frameCnt_d = frameCnt_q;
    if (sx_q == H_LAST) begin
      sx_d = '0;
      if (sy_q == V_LAST) begin
        sy_d       = '0;
        frameCnt_d = frameCnt_q + FRAME_W'(1);
      end else begin
        sy_d = sy_q + CORDW'(1);
      end
    end
  end

  // Position and frame counters; reset restarts the raster at the top-left corner.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      sx_q       <= '0;
      sy_q       <= '0;
      frameCnt_q <= '0;
    end else begin
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      frameCnt_q <= frameCnt_d;
    end
  end

  // Raw timing decoded from the undelayed counters. With a zero back porch the sync end
  // equals the total and may not fit in CORDW, so the sync runs to the end of the line.
  always_comb begin
    hsActive = (sx_q >= HS_START) && ((H_BP == 0) || (sx_q < HS_END));
    vsActive = (sy_q >= VS_START) && ((V_BP == 0) || (sy_q < VS_END));
    hsLevel  = hsActive ? H_POL : ~H_POL;
    vsLevel  = vsActive ? V_POL : ~V_POL;
    deRaw    = ~rst && (sx_q < H_ACT) && (sy_q < V_ACT);
  end

  assign vgaBus.sx          = sx_q;
  assign vgaBus.sy          = sy_q;
  assign vgaBus.de          = deRaw;
  assign vgaBus.line_start  = ~rst && (sx_q == '0);
  assign vgaBus.frame_start = ~rst && (sx_q == '0) && (sy_q == '0);
  assign vgaBus.frame_cnt   = frameCnt_q;

  generate
    if (RENDER_LAT == 0) begin : gNoDelay
      assign hsDly = hsLevel;
      assign vsDly = vsLevel;
      assign deDly = deRaw;
    end else begin : gDelay
      logic [RENDER_LAT-1:0] hsPipe_q, vsPipe_q, dePipe_q;

      // Delay syncs and de by the renderer latency; reset flushes to idle and blanked.
      always_ff @(posedge clk_pix) begin
        if (rst) begin
          hsPipe_q <= {RENDER_LAT{~H_POL}};
          vsPipe_q <= {RENDER_LAT{~V_POL}};
          dePipe_q <= '0;
        end else begin
          hsPipe_q[0] <= hsLevel;
          vsPipe_q[0] <= vsLevel;
          dePipe_q[0] <= deRaw;
          for (int i = 1; i < RENDER_LAT; i++) begin
            hsPipe_q[i] <= hsPipe_q[i-1];
            vsPipe_q[i] <= vsPipe_q[i-1];
            dePipe_q[i] <= dePipe_q[i-1];
          end
        end
      end

      assign hsDly = hsPipe_q[RENDER_LAT-1];
      assign vsDly = vsPipe_q[RENDER_LAT-1];
      assign deDly = dePipe_q[RENDER_LAT-1];
    end
  endgenerate

  // Output register: aligned syncs, colour passed only while the aligned de is set.
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      vgaHsync_q <= ~H_POL;
      vgaVsync_q <= ~V_POL;
      vgaR_q     <= '0;
      vgaG_q     <= '0;
      vgaB_q     <= '0;
    end else begin
      vgaHsync_q <= hsDly;
      vgaVsync_q <= vsDly;
      vgaR_q     <= deDly ? vgaBus.pix_r_in : '0;
      vgaG_q     <= deDly ? vgaBus.pix_g_in : '0;
      vgaB_q     <= deDly ? vgaBus.pix_b_in : '0;
    end
  end

  assign vgaBus.vga_hsync = vgaHsync_q;
  assign vgaBus.vga_vsync = vgaVsync_q;
  assign vgaBus.vga_r     = vgaR_q;
  assign vgaBus.vga_g     = vgaG_q;
  assign vgaBus.vga_b     = vgaB_q;

endmodule

// File: tb/tb_vga_display_core.sv
// Testbench for vga_display_core: two small-raster instances (active-low and
// active-high syncs) checked cycle by cycle against a model and scoreboard, plus a
// default 640x480 instance checked for line length and hsync width.
module tb_vga_display_core;

  localparam int CW = 4;
  localparam int FW = 3;

  typedef struct {
    logic       hs;
    logic       vs;
    logic       hs2;
    logic       vs2;
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } expT;

  typedef struct {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } pixT;

  typedef struct {
    int rstCycles;
    int runCycles;
    int expSx;
    int expSy;
    int expFrame;
  } vecT;

  logic clk_pix = 1'b0;
  logic rst;
  logic rstBig;

  expT expQ[$];
  pixT pixQ[$];
  int  checks = 0;
  int  errors = 0;
  int  mSx = 0;
  int  mSy = 0;
  int  mFrame = 0;
  bit  modelValid = 1'b0;

  // Pixel clock, 10 time units per cycle.
  always #5 clk_pix = ~clk_pix;

  vga_display_core_if #(.CORDW(CW), .RW(3), .GW(3), .BW(2), .FRAME_W(FW)) busA ();
  vga_display_core_if #(.CORDW(CW), .RW(3), .GW(3), .BW(2), .FRAME_W(FW)) busB ();
  vga_display_core_if busBig ();

  vga_display_core #(
    .CORDW(CW), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .RW(3), .GW(3), .BW(2),
    .RENDER_LAT(2), .FRAME_W(FW)
  ) dutA (
    .clk_pix(clk_pix),
    .rst(rst),
    .vgaBus(busA)
  );

  vga_display_core #(
    .CORDW(CW), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .RW(3), .GW(3), .BW(2),
    .RENDER_LAT(2), .FRAME_W(FW)
  ) dutB (
    .clk_pix(clk_pix),
    .rst(rst),
    .vgaBus(busB)
  );

  vga_display_core dutBig (
    .clk_pix(clk_pix),
    .rst(rstBig),
    .vgaBus(busBig)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One pixel cycle on the small instances: drive the renderer, compare counters and
  // registered outputs, queue the expectation for this position, then advance the model.
  task automatic applyStimulus(input logic rstIn);
    pixT c;
    pixT drv;
    expT e;
    logic deM, hsA, vsA;
    @(negedge clk_pix);
    rst = rstIn;
    drv.r = 3'($urandom);
    drv.g = 3'($urandom);
    drv.b = 2'($urandom);
    c = drv;
    deM = !rstIn && (mSx < 8) && (mSy < 4);
    if (!rstIn) begin
      c.r = 3'(mSx);
      c.g = 3'($urandom);
      c.b = 2'($urandom);
      pixQ.push_back(c);
      if (pixQ.size() > 2) drv = pixQ.pop_front();
    end
    busA.pix_r_in = drv.r;
    busA.pix_g_in = drv.g;
    busA.pix_b_in = drv.b;
    busB.pix_r_in = drv.r;
    busB.pix_g_in = drv.g;
    busB.pix_b_in = drv.b;
    #1;
    if (modelValid) begin
      checkOutput("sx", 32'(busA.sx), 32'(mSx));
      checkOutput("sy", 32'(busA.sy), 32'(mSy));
      checkOutput("frame_cnt", 32'(busA.frame_cnt), 32'(mFrame));
    end
    checkOutput("de", 32'(busA.de), 32'(deM));
    checkOutput("line_start", 32'(busA.line_start), 32'(!rstIn && mSx == 0));
    checkOutput("frame_start", 32'(busA.frame_start), 32'(!rstIn && mSx == 0 && mSy == 0));
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("vga_hsync", 32'(busA.vga_hsync), 32'(e.hs));
      checkOutput("vga_vsync", 32'(busA.vga_vsync), 32'(e.vs));
      checkOutput("vga_r", 32'(busA.vga_r), 32'(e.r));
      checkOutput("vga_g", 32'(busA.vga_g), 32'(e.g));
      checkOutput("vga_b", 32'(busA.vga_b), 32'(e.b));
      checkOutput("hsync_pos", 32'(busB.vga_hsync), 32'(e.hs2));
      checkOutput("vsync_pos", 32'(busB.vga_vsync), 32'(e.vs2));
    end
    if (!rstIn) begin
      hsA = (mSx >= 9) && (mSx < 11);
      vsA = (mSy == 5);
      e.hs  = !hsA;
      e.vs  = !vsA;
      e.hs2 = hsA;
      e.vs2 = vsA;
      e.r   = deM ? c.r : 3'd0;
      e.g   = deM ? c.g : 3'd0;
      e.b   = deM ? c.b : 2'd0;
      expQ.push_back(e);
    end
    @(posedge clk_pix);
    if (rstIn) begin
      mSx = 0;
      mSy = 0;
      mFrame = 0;
      modelValid = 1'b1;
      expQ.delete();
      pixQ.delete();
      e = '{hs: 1'b1, vs: 1'b1, hs2: 1'b0, vs2: 1'b0, r: 3'd0, g: 3'd0, b: 2'd0};
      repeat (3) expQ.push_back(e);
    end else if (mSx == 11) begin
      mSx = 0;
      if (mSy == 6) begin
        mSy = 0;
        mFrame = (mFrame + 1) % 8;
      end else begin
        mSy = mSy + 1;
      end
    end else begin
      mSx = mSx + 1;
    end
  endtask

  // Stimulus: full-size timing check first, then the table of raster sequences.
  initial begin
    vecT vecs[10];
    int  firstLow, lowCount, secondLine, syAtSecond;

    vecs[0] = '{2, 0, 0, 0, 0};
    vecs[1] = '{0, 11, 11, 0, 0};
    vecs[2] = '{0, 1, 0, 1, 0};
    vecs[3] = '{0, 71, 11, 6, 0};
    vecs[4] = '{0, 1, 0, 0, 1};
    vecs[5] = '{0, 588, 0, 0, 0};
    vecs[6] = '{0, 113, 5, 2, 1};
    vecs[7] = '{1, 0, 0, 0, 0};
    vecs[8] = '{0, 30, 6, 2, 0};
    vecs[9] = '{0, 54, 0, 0, 1};

    rst = 1'b1;
    rstBig = 1'b1;
    busA.pix_r_in = '0;
    busA.pix_g_in = '0;
    busA.pix_b_in = '0;
    busB.pix_r_in = '0;
    busB.pix_g_in = '0;
    busB.pix_b_in = '0;
    busBig.pix_r_in = 3'd5;
    busBig.pix_g_in = 3'd2;
    busBig.pix_b_in = 2'd1;

    $display("[TB] 640x480 line and hsync timing");
    repeat (2) @(negedge clk_pix);
    rstBig = 1'b0;
    firstLow = -1;
    lowCount = 0;
    secondLine = -1;
    syAtSecond = -1;
    #1;
    for (int k = 0; k < 2000; k++) begin
      if (busBig.vga_hsync == 1'b0) begin
        if (firstLow < 0) firstLow = k;
        if (k < 800) lowCount++;
      end
      if (k > 0 && busBig.line_start && secondLine < 0) begin
        secondLine = k;
        syAtSecond = int'(busBig.sy);
      end
      @(negedge clk_pix);
      #1;
    end
    checkOutput("big first hsync", 32'(firstLow), 32'd657);
    checkOutput("big hsync width", 32'(lowCount), 32'd96);
    checkOutput("big line period", 32'(secondLine), 32'd800);
    checkOutput("big sy after line", 32'(syAtSecond), 32'd1);

    $display("[TB] small raster sequences");
    for (int i = 0; i < 10; i++) begin
      repeat (vecs[i].rstCycles) applyStimulus(1'b1);
      repeat (vecs[i].runCycles) applyStimulus(1'b0);
      #1;
      checkOutput($sformatf("vec%0d sx", i), 32'(busA.sx), 32'(vecs[i].expSx));
      checkOutput($sformatf("vec%0d sy", i), 32'(busA.sy), 32'(vecs[i].expSy));
      checkOutput($sformatf("vec%0d frame", i), 32'(busA.frame_cnt), 32'(vecs[i].expFrame));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
